// File: rtl/apu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : apu_pkg
//  Description : Shared APU types, frame-sequencer step masks and tick decode.
//  Revision    : 1.0
// ============================================================================
package apu_pkg;

    typedef logic [2:0] fs_step_t;

    typedef struct packed {
        logic length;
        logic sweep;
        logic envelope;
    } fs_ticks_t;

    localparam logic [7:0] FS_LENGTH_MASK   = 8'b0101_0101;
    localparam logic [7:0] FS_SWEEP_MASK    = 8'b0100_0100;
    localparam logic [7:0] FS_ENVELOPE_MASK = 8'b1000_0000;
    localparam int         GB_FRAME_DIV     = 8192;

    // Sweep and envelope are additionally qualified by their channel gates.
    function automatic fs_ticks_t fs_decode(input fs_step_t s,
                                            input logic     sweep_en,
                                            input logic     env_en);
        fs_ticks_t t;
        t.length   = FS_LENGTH_MASK[s];
        t.sweep    = FS_SWEEP_MASK[s] & sweep_en;
        t.envelope = FS_ENVELOPE_MASK[s] & env_en;
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apu_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : apu_prescaler
//  Description : Modulo-CLK_DIV counter emitting a one-cycle strobe on wrap.
//  Revision    : 1.0
// ============================================================================
module apu_prescaler
    import apu_pkg::*;
#(
    parameter int CLK_DIV   = GB_FRAME_DIV,
    parameter int DIV_WIDTH = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic strobe
);

    localparam logic [DIV_WIDTH-1:0] CNT_LAST = DIV_WIDTH'(CLK_DIV - 1);

    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic [DIV_WIDTH-1:0] div_cnt_d;
    logic                 at_last;

    assign at_last = (div_cnt_q == CNT_LAST);
    assign strobe  = at_last && enable && !clear;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clear || !enable || at_last) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apu_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : apu_frame_sequencer
//  Description : 512 Hz 8-step frame sequencer issuing length/sweep/envelope ticks.
//  Revision    : 1.0
// ============================================================================
module apu_frame_sequencer
    import apu_pkg::*;
#(
    parameter int CLK_DIV   = GB_FRAME_DIV,
    parameter int DIV_WIDTH = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       restart,
    input  logic       sweep_enable,
    input  logic       envelope_enable,
    output logic       length_tick,
    output logic       sweep_tick,
    output logic       envelope_tick,
    output logic [2:0] step,
    output logic       active
);

    logic      strobe;
    fs_step_t  step_q, step_d;
    fs_ticks_t ticks_q, ticks_d;
    logic      active_q, active_d;

    apu_prescaler #(
        .CLK_DIV   (CLK_DIV),
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (restart),
        .strobe (strobe)
    );

    // Ticks come from the step being left, so they trail the strobe by one cycle.
    always_comb begin
        step_d   = step_q;
        ticks_d  = '0;
        active_d = enable && !restart;
        if (restart || !enable) begin
            step_d = '0;
        end else if (strobe) begin
            step_d  = step_q + 3'd1;
            ticks_d = fs_decode(step_q, sweep_enable, envelope_enable);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_q   <= '0;
            ticks_q  <= '0;
            active_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            ticks_q  <= ticks_d;
            active_q <= active_d;
        end
    end

    assign length_tick   = ticks_q.length;
    assign sweep_tick    = ticks_q.sweep;
    assign envelope_tick = ticks_q.envelope;
    assign step          = step_q;
    assign active        = active_q;

endmodule
`default_nettype wire
